// File: rtl/period_meter_pkg.sv
// Shared types and constants for the period meter: FSM state encoding,
// default counter width and the ratio_code values with their decoder.
package period_meter_pkg;

    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_t;

    localparam logic [2:0] RC_NONE  = 3'd0;
    localparam logic [2:0] RC_DIV2  = 3'd1;
    localparam logic [2:0] RC_DIV4  = 3'd2;
    localparam logic [2:0] RC_DIV8  = 3'd3;
    localparam logic [2:0] RC_DIV16 = 3'd4;

    // Map a measured period onto the power-of-two divider it matches, if any.
    function automatic logic [2:0] ratio_decode(input logic [31:0] p);
        case (p)
            32'd2:   return RC_DIV2;
            32'd4:   return RC_DIV4;
            32'd8:   return RC_DIV8;
            32'd16:  return RC_DIV16;
            default: return RC_NONE;
        endcase
    endfunction

endpackage

// File: rtl/period_meter_sync_edge_detect.sv
// Brings the asynchronous divided clock into the clk domain through two
// flops and flags each rising edge with a one-cycle registered pulse.
module sync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic meta_reg;
    logic sync_reg;
    logic dly_reg;

    // Two-flop synchronizer, a delayed copy for edge detection, and a
    // registered edge pulse so the meter sees the edge three edges after
    // the first sample of din high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
            dly_reg  <= 1'b0;
            rise     <= 1'b0;
        end else begin
            meta_reg <= din;
            sync_reg <= meta_reg;
            dly_reg  <= sync_reg;
            rise     <= sync_reg & ~dly_reg;
        end
    end

endmodule

// File: rtl/period_meter.sv
// Measures the period of an asynchronous divided clock in clk cycles,
// hands each measurement out through a valid/ready register, reports
// lock (two equal consecutive periods), timeout and overwrite events.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             div_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    input  logic             period_ready,
    output logic [2:0]       ratio_code,
    output logic             locked,
    output logic             overflow,
    output logic             overrun
);

    state_t           state_reg;
    logic [CNT_W-1:0] count_reg;
    logic             have_prev_reg;   // a capture exists in this measurement run
    logic             div_rise;
    logic             capture;
    logic             timeout_hit;

    sync_edge_detect u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (div_in),
        .rise  (div_rise)
    );

    // A period is captured only on an edge while already measuring; the
    // first edge from IDLE or TIMEOUT merely starts the count.
    assign capture     = enable && (state_reg == ST_MEASURE) && div_rise;
    assign timeout_hit = enable && (state_reg == ST_MEASURE) && !div_rise
                         && (count_reg == {CNT_W{1'b1}});

    // Measurement FSM: state, running count, overflow flag and the
    // "previous capture is comparable" flag used by the lock detector.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            count_reg     <= '0;
            overflow      <= 1'b0;
            have_prev_reg <= 1'b0;
        end else if (!enable) begin
            state_reg     <= ST_IDLE;
            count_reg     <= '0;
            have_prev_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (div_rise) begin
                        state_reg     <= ST_MEASURE;
                        count_reg     <= CNT_W'(1);
                        have_prev_reg <= 1'b0;
                    end
                end
                ST_MEASURE: begin
                    if (div_rise) begin
                        count_reg     <= CNT_W'(1);
                        have_prev_reg <= 1'b1;
                    end else if (timeout_hit) begin
                        state_reg     <= ST_TIMEOUT;
                        overflow      <= 1'b1;
                        have_prev_reg <= 1'b0;
                    end else begin
                        count_reg <= count_reg + CNT_W'(1);
                    end
                end
                ST_TIMEOUT: begin
                    if (div_rise) begin
                        state_reg <= ST_MEASURE;
                        count_reg <= CNT_W'(1);
                        overflow  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    count_reg <= '0;
                end
            endcase
        end
    end

    // Output register with valid/ready handshake; a capture always wins
    // over acceptance, and overwriting an unaccepted value pulses overrun.
    // While disabled the held measurement is left untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (capture) begin
                period       <= count_reg;
                period_valid <= 1'b1;
                overrun      <= period_valid && !period_ready;
                locked       <= have_prev_reg && (count_reg == period);
            end else begin
                if (timeout_hit) begin
                    locked <= 1'b0;
                end
                if (enable && period_valid && period_ready) begin
                    period_valid <= 1'b0;
                end
            end
        end
    end

    assign ratio_code = ratio_decode(32'(period));

endmodule
